// File: rtl/fft_bin_reader.sv
// fft_bin_reader: per-frame reader of selected FFT magnitude bins from BRAM,
// streaming peak-held (decaying) magnitudes with a valid/ready handshake.
module fft_bin_reader #(
    parameter int NUM_BINS_MAX = 6,
    parameter int READ_LATENCY = 2,
    parameter int DECAY = 4,
    localparam int IW = NUM_BINS_MAX > 1 ? $clog2(NUM_BINS_MAX) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         fft_we,
    input  logic                         fft_last,
    input  logic [3:0]                   bin,
    input  logic [10*NUM_BINS_MAX-1:0]   bin_addr,
    output logic [9:0]                   bram_addrb,
    input  logic [8:0]                   bram_doutb,
    output logic [8:0]                   mag_data,
    output logic [IW-1:0]                mag_index,
    output logic                         mag_valid,
    input  logic                         mag_ready,
    output logic                         julian_done
);
    typedef enum logic [2:0] {IDLE, LATCH, READ, WAIT, PRESENT} state_t;
    state_t state, state_nx;
    logic [3:0] count, count_in, k_inc;
    logic [9:0] addr_r [NUM_BINS_MAX];
    logic [8:0] held [NUM_BINS_MAX];
    logic [IW-1:0] k;
    logic [7:0] wcnt;
    logic overrun, frame_raw, last, wait_done;
    logic [8:0] decayed, peak;

    assign count_in = bin > 4'(NUM_BINS_MAX) ? 4'(NUM_BINS_MAX) : bin;
    assign k_inc = 4'(k) + 4'd1;
    assign last = k_inc >= count;
    assign wait_done = wcnt == 8'(READ_LATENCY);
    assign decayed = held[k] > 9'(DECAY) ? held[k] - 9'(DECAY) : 9'd0;
    // An overrun anywhere since the previous frame makes the history untrustworthy
    assign peak = (overrun || frame_raw) ? bram_doutb : (bram_doutb > decayed ? bram_doutb : decayed);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = fft_last ? LATCH : IDLE;
            LATCH:   state_nx = count == 4'd0 ? IDLE : READ;
            READ:    state_nx = WAIT;
            WAIT:    state_nx = wait_done ? PRESENT : WAIT;
            PRESENT: state_nx = mag_ready ? (last ? IDLE : READ) : PRESENT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mag_valid = state == PRESENT;
        mag_data = held[k];
        mag_index = k;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            julian_done <= 1'b1;
            bram_addrb <= '0;
            k <= '0;
            wcnt <= '0;
            count <= '0;
            overrun <= 1'b0;
            frame_raw <= 1'b0;
            for (int i = 0; i < NUM_BINS_MAX; i++) begin
                held[i] <= '0;
                addr_r[i] <= '0;
            end
        end else begin
            if (state == IDLE && fft_last) begin
                count <= count_in;
                for (int i = 0; i < NUM_BINS_MAX; i++) addr_r[i] <= bin_addr[10*i +: 10];
                k <= '0;
                julian_done <= 1'b0;
                frame_raw <= overrun;
                overrun <= 1'b0;
            end else begin
                if (fft_we && !julian_done) overrun <= 1'b1;
                if (state == IDLE) julian_done <= 1'b1;
            end
            if (state == LATCH) bram_addrb <= addr_r[0];
            if (state == READ) wcnt <= 8'd1;
            if (state == WAIT) begin
                wcnt <= wcnt + 8'd1;
                if (wait_done) held[k] <= peak;
            end
            if (state == PRESENT && mag_ready) begin
                if (last) begin
                    k <= '0;
                    julian_done <= 1'b1;
                end else begin
                    k <= k_inc[IW-1:0];
                    bram_addrb <= addr_r[k_inc[IW-1:0]];
                end
            end
        end
    end
endmodule
